fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the pipelined RV32I core.
- Holds the PC, drives the instruction-memory address, and selects the next PC from three sources: sequential PC+4, branch/JAL target, or JALR target.
- The branch/JAL target is computed from the sign-extended immediate fed back from Execute.
- Its registered instruction output feeds the decode-side immediate extender and control decoder.

Parameters:
- WIDTH, 32, datapath/address width.
- RESET_PC, 32'hBFC00000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) inserted into IF/ID.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- stall  input  1  hazard-unit stall: hold PC and IF/ID.
- flush  input  1  hazard-unit flush: load bubble into IF/ID.
- PCsrc  input  2  00 = PC+4; 01 = PCE+ImmExtE (branch/JAL); 10 = JALR; 11 reserved, treated as 00.
- PCE  input  WIDTH  PC of the instruction in Execute.
- ImmExtE  input  WIDTH  sign-extended immediate in Execute.
- ALUResultE  input  WIDTH  JALR base+offset sum from the Execute ALU.
- imem_addr  output  WIDTH  instruction-memory address; combinational, equals PCF.
- imem_rdata  input  WIDTH  instruction word; combinational read of imem_addr.
- PCF  output  WIDTH  current fetch PC.
- InstrD  output  WIDTH  IF/ID instruction.
- PCD  output  WIDTH  IF/ID PC.
- PCPlus4D  output  WIDTH  IF/ID PC+4.
- ValidD  output  1  IF/ID holds a real instruction.
- MisalignF  output  1  sticky flag: a redirect target was not word-aligned.
- FetchCount  output  32  count of valid instructions captured into IF/ID.

Behaviour:
- Clocking and reset
  - All state updates on the rising edge of clk.
  - Reset is sampled at the edge only; there is no asynchronous path.
  - Reset values: PCF = RESET_PC; InstrD = NOP_INSTR; PCD = 0; PCPlus4D = 0; ValidD = 0; MisalignF = 0; FetchCount = 0.
  - Reset mid-operation discards everything on the next edge: pending redirect, stall and flush are all ignored.
- Next-PC selection (priority order)
  - Reset.
  - Redirect (PCsrc = 01 or 10): loads the target. Redirect overrides stall.
  - Stall: hold PCF.
  - Otherwise: PCF + 4.
- Target arithmetic
  - Branch/JAL target = PCE + ImmExtE, modulo 2^WIDTH.
  - JALR target = {ALUResultE[WIDTH-1:1], 1'b0}.
  - PC+4 wraps 32'hFFFFFFFC -> 0 with no flag.
- Misalignment
  - If the selected redirect target has bit[1] = 1, MisalignF is set on that edge.
  - MisalignF stays set until reset.
  - The PC is still loaded with the target; no trap is generated here.
- IF/ID register (priority order)
  - Reset.
  - Kill (flush OR redirect): load bubble — InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, ValidD = 0.
  - Stall: hold all IF/ID fields.
  - Otherwise: InstrD = imem_rdata, PCD = PCF, PCPlus4D = PCF + 4, ValidD = 1.
- Simultaneous events
  - Stall + flush: PC holds, IF/ID takes the bubble.
  - Stall + redirect: PC loads the target, IF/ID takes the bubble.
  - Flush + redirect: same result as redirect alone.
- FetchCount
  - Increments by 1 on each edge where IF/ID loads with ValidD = 1.
  - Wraps 32'hFFFFFFFF -> 0.
  - Holds during stall and during bubble insertion.
- Latency
  - Instruction at PCF appears on InstrD one cycle later.
  - A redirect asserted in cycle n gives PCF = target in cycle n+1 and its instruction on InstrD in cycle n+2.
  - Exactly one bubble follows each redirect; the instruction already in Decode is the hazard unit's responsibility.
- Outputs change only at clock edges, except imem_addr, which follows PCF.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles, then release -> PCF = 32'hBFC00000, InstrD = 32'h00000013, ValidD = 0, FetchCount = 0. After 3 free-running cycles: PCF = 32'hBFC0000C, PCD = 32'hBFC00008, FetchCount = 3.
- Stall: assert stall for 2 cycles with PCF = 32'hBFC00004 -> PCF, InstrD, PCD and FetchCount all hold. Deassert -> PCF = 32'hBFC00008 next edge.
- Branch back: PCsrc = 01, PCE = 32'hBFC00008, ImmExtE = 32'hFFFFFFF8 -> next edge PCF = 32'hBFC00000, InstrD = NOP, ValidD = 0. Following edge InstrD = imem word at 32'hBFC00000, ValidD = 1.
- JALR: PCsrc = 10, ALUResultE = 32'h00001003 -> PCF = 32'h00001002, MisalignF = 1. MisalignF stays 1 through later aligned redirects until rst_n = 0.
- Simultaneous stall + flush, then stall + redirect (PCE = 32'h100, ImmExtE = 32'h10):
  - First cycle: PC holds, ValidD = 0.
  - Second cycle: PCF = 32'h110, ValidD = 0.
- Wrap: redirect to 32'hFFFFFFFC, run 2 cycles -> PCF = 32'h00000000, then 32'h00000004, with PCPlus4D = 0 captured for PCD = 32'hFFFFFFFC. Apply rst_n = 0 mid-stall + redirect -> all outputs return to reset values.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: the fetch side drives the address,
// and the memory returns the word combinationally.
interface fetch_stage_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] imem_addr;
   logic [WIDTH-1:0] imem_rdata;

   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register, with a sticky misaligned-redirect flag and a fetch counter.
module fetch_stage #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = 32'hBFC00000,
   parameter logic [WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic [1:0]        PCsrc,
   input  logic [WIDTH-1:0]  PCE,
   input  logic [WIDTH-1:0]  ImmExtE,
   input  logic [WIDTH-1:0]  ALUResultE,
   fetch_stage_if.master     imem,
   output logic [WIDTH-1:0]  PCF,
   output logic [WIDTH-1:0]  InstrD,
   output logic [WIDTH-1:0]  PCD,
   output logic [WIDTH-1:0]  PCPlus4D,
   output logic              ValidD,
   output logic              MisalignF,
   output logic [31:0]       FetchCount
);

   typedef enum logic [1:0] {
      SRC_SEQ    = 2'b00,
      SRC_BRANCH = 2'b01,
      SRC_JALR   = 2'b10,
      SRC_RSVD   = 2'b11
   } pcsrc_e;

   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] target;
   logic             redirect;
   logic             kill;

   assign imem.imem_addr = PCF;
   assign pc_plus4       = PCF + WIDTH'(4);

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      redirect = 1'b0;
      target   = pc_plus4;
      case (pcsrc_e'(PCsrc))
         SRC_BRANCH: begin
            redirect = 1'b1;
            target   = PCE + ImmExtE;
         end
         SRC_JALR: begin
            redirect = 1'b1;
            target   = ALUResultE & ~WIDTH'(1);
         end
         default: ;
      endcase
   end

   // A redirect also squashes the wrong-path word being fetched this cycle.
   assign kill = flush | redirect;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         PCF        <= RESET_PC;
         InstrD     <= NOP_INSTR;
         PCD        <= '0;
         PCPlus4D   <= '0;
         ValidD     <= 1'b0;
         MisalignF  <= 1'b0;
         FetchCount <= '0;
      end else begin
         // Redirect wins over stall so a resolved branch is never lost.
         if (redirect)
            PCF <= target;
         else if (!stall)
            PCF <= pc_plus4;

         if (redirect && target[1])
            MisalignF <= 1'b1;

         if (kill) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
         end else if (!stall) begin
            InstrD     <= imem.imem_rdata;
            PCD        <= PCF;
            PCPlus4D   <= pc_plus4;
            ValidD     <= 1'b1;
            FetchCount <= FetchCount + 32'd1;
         end
      end
   end

endmodule
